// File: rtl/mul_div_if.sv
// Request/response bundle between the core and the iterative multiply/divide unit.
// The core drives the request side (master); the unit drives busy and the result (slave).
interface mul_div_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5
);
    logic              start;
    logic              flush;
    logic [2:0]        op;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [TAG_W-1:0]  tag_in;
    logic              busy;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag_out;

    modport master (
        output start, flush, op, operand_a, operand_b, tag_in,
        input  busy, result_valid, result, tag_out
    );

    modport slave (
        input  start, flush, op, operand_a, operand_b, tag_in,
        output busy, result_valid, result, tag_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider sharing
// one hi/lo register pair, one bit per cycle, with a tag carried alongside each operation.
module mul_div_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 5
) (
    input  logic     clk,
    input  logic     arst_n,
    mul_div_if.slave bus
);

    localparam int unsigned CntW = $clog2(DATA_W) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic [DATA_W-1:0] opnd_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [CntW-1:0]   cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic              busy_q;
    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic [TAG_W-1:0]  tag_out_q;

    // Accept-time decode
    logic              in_div;
    logic              in_sign_a;
    logic              in_sign_b;
    logic              in_neg_a;
    logic              in_neg_b;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast_path;
    logic [DATA_W-1:0] fast_res;
    logic              accept;

    always_comb begin
        in_div    = bus.op[2];
        in_sign_a = (bus.op == OpMulh) || (bus.op == OpMulhsu) ||
                    (bus.op == OpDiv)  || (bus.op == OpRem);
        in_sign_b = (bus.op == OpMulh) || (bus.op == OpDiv) || (bus.op == OpRem);
        in_neg_a  = in_sign_a & bus.operand_a[DATA_W-1];
        in_neg_b  = in_sign_b & bus.operand_b[DATA_W-1];
        abs_a     = in_neg_a ? -bus.operand_a : bus.operand_a;
        abs_b     = in_neg_b ? -bus.operand_b : bus.operand_b;
        div_zero  = (bus.operand_b == '0);
        // op[0] clear means a signed divide/remainder
        div_ovf   = in_div && !bus.op[0] && (bus.operand_a == MinNeg) && (bus.operand_b == '1);
        fast_path = in_div && (div_zero || div_ovf);
        if (div_zero) begin
            fast_res = bus.op[1] ? bus.operand_a : '1;
        end else begin
            fast_res = bus.op[1] ? '0 : bus.operand_a;
        end
        accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
    end

    // One iteration of either datapath
    logic [DATA_W:0]   mul_sum;
    logic              div_top;
    logic [DATA_W-1:0] div_rem;
    logic              div_ge;
    logic [DATA_W-1:0] step_hi;
    logic [DATA_W-1:0] step_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        // Partial remainder shifted left; div_top is the bit that falls off the top
        div_top = hi_q[DATA_W-1];
        div_rem = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};
        div_ge  = div_top || (div_rem >= opnd_q);
        if (op_q[2]) begin
            step_hi = div_ge ? (div_rem - opnd_q) : div_rem;
            step_lo = {lo_q[DATA_W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // Sign correction and half selection
    logic [2*DATA_W-1:0] prod_mag;
    logic [2*DATA_W-1:0] prod_sgn;
    logic [DATA_W-1:0]   quo_sgn;
    logic [DATA_W-1:0]   rem_sgn;
    logic [DATA_W-1:0]   fix_res;

    always_comb begin
        prod_mag = {hi_q, lo_q};
        prod_sgn = neg_q ? -prod_mag : prod_mag;
        quo_sgn  = neg_q ? -lo_q : lo_q;
        rem_sgn  = rem_neg_q ? -hi_q : hi_q;
        fix_res  = '0;
        if (!op_q[2]) begin
            fix_res = (op_q == OpMul) ? prod_sgn[DATA_W-1:0] : prod_sgn[2*DATA_W-1:DATA_W];
        end else begin
            fix_res = op_q[1] ? rem_sgn : quo_sgn;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else if (bus.flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept) begin
            op_q      <= bus.op;
            tag_q     <= bus.tag_in;
            neg_q     <= in_neg_a ^ in_neg_b;
            rem_neg_q <= in_neg_a;
            opnd_q    <= in_div ? abs_b : abs_a;
            lo_q      <= in_div ? abs_a : abs_b;
            hi_q      <= '0;
            cnt_q     <= '0;
            if (fast_path) begin
                state_q   <= StDone;
                busy_q    <= 1'b0;
                valid_q   <= 1'b1;
                result_q  <= fast_res;
                tag_out_q <= bus.tag_in;
            end else begin
                state_q <= StCalc;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_q <= 1'b0;
                end
                StCalc: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    state_q   <= StDone;
                    busy_q    <= 1'b0;
                    valid_q   <= 1'b1;
                    result_q  <= fix_res;
                    tag_out_q <= tag_q;
                end
                StDone: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.tag_out      = tag_out_q;

endmodule
